// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through data cache with line fill from backing memory
`timescale 1ns/1ps

module data_cache #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cache_address,
    input  logic        cache_read,
    input  logic        cache_write,
    inout  wire  [31:0] cache_data,
    output logic        cache_hit,
    input  logic        invalidate,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ready
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, ACK} state_t;

    state_t             state;
    logic [29:0]        lat_addr;
    logic [OFF_W-1:0]   counter;
    logic [SETS-1:0]    valid;
    logic               inv_pending;
    logic [31:0]        rdata;
    logic               data_drive;

    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [31:0]        data_mem [SETS*LINE_WORDS];

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [OFF_W-1:0]   lat_off;
    logic [IDX_W-1:0]   lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic [OFF_W-1:0]   next_counter;
    logic               req_hit;
    logic               lat_hit;
    logic [31:0]        fill_word;
    logic               unused_byte_bits;

    assign req_off = cache_address[2+OFF_W-1:2];
    assign req_idx = cache_address[2+OFF_W+IDX_W-1:2+OFF_W];
    assign req_tag = cache_address[31:2+OFF_W+IDX_W];

    assign lat_off = lat_addr[OFF_W-1:0];
    assign lat_idx = lat_addr[OFF_W+IDX_W-1:OFF_W];
    assign lat_tag = lat_addr[29:OFF_W+IDX_W];

    assign next_counter = counter + OFF_W'(1);

    // A queued invalidate kills every line at the edge a new request is sampled,
    // so that request must not be allowed to hit on a line that is being cleared.
    assign req_hit = valid[req_idx] && !inv_pending && (tag_mem[req_idx] == req_tag);
    assign lat_hit = valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);

    // On the last fill beat the requested word may be the one arriving right now.
    assign fill_word = (lat_off == counter) ? mem_data_in : data_mem[{lat_idx, lat_off}];

    assign unused_byte_bits = ^cache_address[1:0];

    assign cache_data = data_drive ? rdata : 32'bz;

    // Control FSM: request decode, fill sequencing, write-through and acknowledge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lat_addr     <= '0;
            counter      <= '0;
            valid        <= '0;
            inv_pending  <= 1'b0;
            rdata        <= '0;
            data_drive   <= 1'b0;
            cache_hit    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_data_out <= '0;
        end else begin
            if (state != IDLE && invalidate) begin
                inv_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (invalidate || inv_pending) begin
                        valid       <= '0;
                        inv_pending <= 1'b0;
                    end
                    if (cache_write) begin
                        lat_addr     <= cache_address[31:2];
                        mem_address  <= {cache_address[31:2], 2'b00};
                        mem_data_out <= cache_data;
                        mem_write    <= 1'b1;
                        state        <= WRITE;
                    end else if (cache_read) begin
                        lat_addr <= cache_address[31:2];
                        if (req_hit) begin
                            rdata      <= data_mem[{req_idx, req_off}];
                            cache_hit  <= 1'b1;
                            data_drive <= 1'b1;
                            state      <= ACK;
                        end else begin
                            counter     <= '0;
                            mem_read    <= 1'b1;
                            mem_address <= {cache_address[31:2+OFF_W], {OFF_W{1'b0}}, 2'b00};
                            state       <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        counter <= next_counter;
                        if (&counter) begin
                            valid[lat_idx] <= 1'b1;
                            mem_read       <= 1'b0;
                            rdata          <= fill_word;
                            cache_hit      <= 1'b1;
                            data_drive     <= 1'b1;
                            state          <= ACK;
                        end else begin
                            mem_address <= {lat_addr[29:OFF_W], next_counter, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        cache_hit <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    cache_hit  <= 1'b0;
                    data_drive <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag storage: fill beats, tag capture on the last beat, and write-hit updates.
    always_ff @(posedge clock) begin
        if (state == FILL && mem_ready) begin
            data_mem[{lat_idx, counter}] <= mem_data_in;
            if (&counter) begin
                tag_mem[lat_idx] <= lat_tag;
            end
        end
        if (state == WRITE && mem_ready && lat_hit) begin
            data_mem[{lat_idx, lat_off}] <= mem_data_out;
        end
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The module SHALL take parameter SETS, default 16, giving the number of lines (power of two, 2..256).
REQ-002 The module SHALL take parameter LINE_WORDS, default 4, giving 32-bit words per line (power of two, 2..16).
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cache_address  input  32  byte address from the load/store unit; bits [1:0] ignored.
REQ-006 cache_read  input  1  read request, held by the initiator until cache_hit.
REQ-007 cache_write  input  1  write request, held by the initiator until cache_hit.
REQ-008 cache_data  inout  32  write data in; read data driven by this block only while acknowledging a read, high-Z otherwise.
REQ-009 cache_hit  output  1  one-cycle acknowledge that a request has completed.
REQ-010 invalidate  input  1  pulse requesting that all lines be cleared.
REQ-011 mem_address  output  32  word-aligned backing-memory address.
REQ-012 mem_read  output  1  memory read strobe.
REQ-013 mem_write  output  1  memory write strobe.
REQ-014 mem_data_out  output  32  memory write data.
REQ-015 mem_data_in  input  32  memory read data, valid when mem_ready=1.
REQ-016 mem_ready  input  1  memory completes the current strobe this cycle.

Function
REQ-017 Organisation SHALL be direct-mapped: offset=addr[2+log2(LINE_WORDS)-1:2], index=next log2(SETS) bits, tag=remaining upper bits; one valid bit and one tag per line.
REQ-018 The FSM SHALL have states IDLE, FILL, WRITE and ACK; requests are sampled only in IDLE.
REQ-019 IDLE, cache_write=1: go to WRITE; cache_write takes priority when cache_read=1 in the same cycle.
REQ-020 IDLE, cache_read=1 with valid line and matching tag: go to ACK; read latency is 2 edges from request to cache_hit.
REQ-021 IDLE, cache_read=1 on a miss: go to FILL, latch the address and clear the word counter to 0.
REQ-022 FILL SHALL hold mem_read=1 and mem_address={tag,index,counter,2'b00}; on each mem_ready, store mem_data_in into word <counter> and increment the counter.
REQ-023 FILL SHALL, on the mem_ready for word LINE_WORDS-1, set valid, write the tag and go to ACK; the fill SHALL always start at word 0 (no critical-word-first).
REQ-024 Write policy SHALL be write-through, no-write-allocate.
REQ-025 WRITE SHALL hold mem_write=1, mem_address=latched word address and mem_data_out=latched cache_data until mem_ready, then go to ACK.
REQ-026 WRITE SHALL, on a hit, update the cached word in the same edge as mem_ready; on a miss the array, tags and valid bits SHALL stay unchanged.
REQ-027 ACK SHALL assert cache_hit=1 for exactly one cycle and then return to IDLE; for a read, cache_data SHALL carry the addressed word during that cycle only.
REQ-028 mem_read and mem_write SHALL never both be 1; both SHALL be 0 in IDLE and ACK.
REQ-029 invalidate in IDLE SHALL clear every valid bit at the next edge; a request sampled in the same cycle SHALL be evaluated against the pre-clear valid bits.
REQ-030 invalidate outside IDLE SHALL set a pending flag; the clear SHALL be applied on the first edge in IDLE, and that line SHALL be cleared even if a fill just completed.
REQ-031 A mem_ready with no strobe active SHALL be ignored.

Reset
REQ-032 On reset the block SHALL enter IDLE, clear all valid bits, the pending-invalidate flag and the word counter, and drive cache_hit=0, mem_read=0, mem_write=0, mem_address=0, mem_data_out=0 and cache_data high-Z.
REQ-033 Reset during FILL or WRITE SHALL abandon the operation, leave no line valid and drop any strobe immediately.
REQ-034 The contents of the data array need not be reset.

Verification
REQ-035 Cold read 0x0000_1234, memory returns 0xA0..0xA3 with mem_ready each cycle -> mem_address 0x1230, 0x1234, 0x1238, 0x123C; cache_hit once; cache_data=0xA1.
REQ-036 Reread 0x0000_1238 -> no mem_read; cache_hit 2 edges after the request; cache_data=0xA2.
REQ-037 Write 0xDEAD_BEEF to 0x1234 with mem_ready delayed 3 cycles -> mem_write held 4 cycles; cache_hit once; a following read of 0x1234 returns 0xDEAD_BEEF with no fill.
REQ-038 Write to 0x0000_9000 (miss), then read 0x9000 -> the read performs a full 4-word fill.
REQ-039 invalidate during a fill -> the fill completes and the read is acknowledged; the next read of the same line triggers a new fill.
REQ-040 Reset asserted mid-FILL -> mem_read drops asynchronously; after reset, a read of the same address triggers a refill.
